// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: data width, register count, address width and the
// hard-wired zero register index.
package cpu_pkg;

  localparam int DW       = 16;
  localparam int NREG     = 16;
  localparam int AW       = $clog2(NREG);
  localparam int ZERO_REG = 0;

endpackage : cpu_pkg

// File: rtl/wb_regfile.sv
// Architectural register file for the writeback stage: one write port, two
// combinational read ports, asynchronous clear and register 0 held at zero.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  // Next-state of the file: only the addressed entry changes, and writes aimed at R0 are dropped.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we && (waddr != ZERO_ADDR)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Storage flops, cleared asynchronously so a write in flight at reset never lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports mask R0 so it reads zero even if storage were ever disturbed.
  always_comb begin
    ra_data = (ra_addr == ZERO_ADDR) ? '0 : regs_q[ra_addr];
    rb_data = (rb_addr == ZERO_ADDR) ? '0 : regs_q[rb_addr];
  end

endmodule : wb_regfile

// File: rtl/wb_stage.sv
// Writeback pipeline stage: stage register with stall/flush, retirement into
// the register file, read-port bypass from the stage and a retired counter.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_rd,
  input  logic          in_we,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          wb_we,
  output logic [15:0]   retired
);

  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic          valid_q, valid_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] data_q, data_d;
  logic          we_q, we_d;
  logic [15:0]   retired_q, retired_d;
  logic          retire;
  logic [DW-1:0] rf_ra_data, rf_rb_data;
  logic          hit_a, hit_b;

  // Stage register next-state: flush wins over stall, stall holds, otherwise load.
  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    we_d    = we_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d = in_valid;
      rd_d    = in_rd;
      data_d  = in_data;
      we_d    = in_we;
    end
  end

  // Retirement happens on an edge that lets a valid stage leave; the counter wraps naturally.
  always_comb begin
    retire    = valid_q && !stall && !flush;
    retired_d = retired_q + {15'd0, retire};
  end

  // Stage and counter flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      retired_q <= '0;
    end else begin
      valid_q   <= valid_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      we_q      <= we_d;
      retired_q <= retired_d;
    end
  end

  wb_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (retire && we_q),
    .waddr   (rd_q),
    .wdata   (data_q),
    .ra_addr (ra_addr),
    .rb_addr (rb_addr),
    .ra_data (rf_ra_data),
    .rb_data (rf_rb_data)
  );

  // Bypass the not-yet-written stage value onto the read ports, including while stalled.
  always_comb begin
    hit_a   = valid_q && we_q && (rd_q == ra_addr) && (ra_addr != ZERO_ADDR);
    hit_b   = valid_q && we_q && (rd_q == rb_addr) && (rb_addr != ZERO_ADDR);
    ra_data = hit_a ? data_q : rf_ra_data;
    rb_data = hit_b ? data_q : rf_rb_data;
  end

  assign wb_valid = valid_q;
  assign wb_rd    = rd_q;
  assign wb_data  = data_q;
  assign wb_we    = we_q;
  assign retired  = retired_q;

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: reset, bypass, R0, stall, flush,
// back-to-back writes, counter wrap and reset during a stalled write.
module tb_wb_stage;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_rd;
  logic          in_we;
  logic          stall;
  logic          flush;
  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          wb_we;
  logic [15:0]   retired;

  int checks = 0;
  int errors = 0;

  wb_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .in_we    (in_we),
    .stall    (stall),
    .flush    (flush),
    .ra_addr  (ra_addr),
    .rb_addr  (rb_addr),
    .ra_data  (ra_data),
    .rb_data  (rb_data),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .wb_we    (wb_we),
    .retired  (retired)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the memory-stage inputs and pipeline controls.
  task automatic applyStimulus(input logic v, input logic [AW-1:0] rd,
                               input logic [DW-1:0] data, input logic we,
                               input logic st, input logic fl);
    in_valid = v;
    in_rd    = rd;
    in_data  = data;
    in_we    = we;
    stall    = st;
    flush    = fl;
  endtask

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Set read addresses and let the read muxes settle.
  task automatic readAddr(input logic [AW-1:0] a, input logic [AW-1:0] b);
    ra_addr = a;
    rb_addr = b;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    readAddr(4'd0, 4'd0);
    #12;
    rst_n = 1'b1;
    tick();

    // Reset state: every register reads zero, counter zero, stage empty
    checkOutput("reset_retired", 32'(retired), 32'h0);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'h0);
    for (int i = 0; i < 16; i++) begin
      readAddr(AW'(i), AW'(15 - i));
      checkOutput($sformatf("reset_ra_r%0d", i), 32'(ra_data), 32'h0);
      checkOutput($sformatf("reset_rb_r%0d", 15 - i), 32'(rb_data), 32'h0);
    end

    // Write 0xBEEF to r3: bypass after capture, file after the next edge
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    readAddr(4'd3, 4'd3);
    checkOutput("r3_bypass_ra", 32'(ra_data), 32'hBEEF);
    checkOutput("r3_bypass_rb", 32'(rb_data), 32'hBEEF);
    checkOutput("r3_wb_rd", 32'(wb_rd), 32'h3);
    checkOutput("r3_retired_before", 32'(retired), 32'h0);
    tick();
    checkOutput("r3_file", 32'(ra_data), 32'hBEEF);
    checkOutput("r3_wb_valid_cleared", 32'(wb_valid), 32'h0);
    checkOutput("r3_retired_after", 32'(retired), 32'h1);

    // Write to r0 is discarded but still retires
    applyStimulus(1'b1, 4'd0, 16'h1234, 1'b1, 1'b0, 1'b0);
    readAddr(4'd0, 4'd3);
    checkOutput("r0_before", 32'(ra_data), 32'h0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("r0_in_stage", 32'(ra_data), 32'h0);
    checkOutput("r0_wb_data", 32'(wb_data), 32'h1234);
    checkOutput("r0_other_port_r3", 32'(rb_data), 32'hBEEF);
    tick();
    checkOutput("r0_after", 32'(ra_data), 32'h0);
    checkOutput("r0_retired", 32'(retired), 32'h2);

    // Capture r5 = 0x00AA then stall for three edges
    applyStimulus(1'b1, 4'd5, 16'h00AA, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    readAddr(4'd5, 4'd5);
    checkOutput("stall_bypass_start", 32'(ra_data), 32'h00AA);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("stall_bypass_ra_%0d", i), 32'(ra_data), 32'h00AA);
      checkOutput($sformatf("stall_bypass_rb_%0d", i), 32'(rb_data), 32'h00AA);
      checkOutput($sformatf("stall_retired_%0d", i), 32'(retired), 32'h2);
      checkOutput($sformatf("stall_wb_valid_%0d", i), 32'(wb_valid), 32'h1);
      checkOutput($sformatf("stall_file_r5_%0d", i), 32'(dut.u_regfile.regs_q[5]), 32'h0);
    end
    stall = 1'b0;
    tick();
    checkOutput("stall_release_r5", 32'(ra_data), 32'h00AA);
    checkOutput("stall_release_file_r5", 32'(dut.u_regfile.regs_q[5]), 32'h00AA);
    checkOutput("stall_release_retired", 32'(retired), 32'h3);

    // Capture r7 = 0x5555 then flush together with stall
    applyStimulus(1'b1, 4'd7, 16'h5555, 1'b1, 1'b0, 1'b0);
    tick();
    readAddr(4'd7, 4'd5);
    checkOutput("flush_bypass_before", 32'(ra_data), 32'h5555);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("flush_wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("flush_r7_read", 32'(ra_data), 32'h0);
    checkOutput("flush_retired", 32'(retired), 32'h3);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("flush_r7_file", 32'(dut.u_regfile.regs_q[7]), 32'h0);
    checkOutput("flush_retired_later", 32'(retired), 32'h3);

    // Back-to-back writes to r9: younger value wins in bypass and in the file
    applyStimulus(1'b1, 4'd9, 16'h1111, 1'b1, 1'b0, 1'b0);
    tick();
    readAddr(4'd9, 4'd9);
    checkOutput("b2b_first_bypass", 32'(ra_data), 32'h1111);
    applyStimulus(1'b1, 4'd9, 16'h2222, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("b2b_second_bypass", 32'(ra_data), 32'h2222);
    checkOutput("b2b_file_older", 32'(dut.u_regfile.regs_q[9]), 32'h1111);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("b2b_file_younger", 32'(rb_data), 32'h2222);
    checkOutput("b2b_retired", 32'(retired), 32'h5);

    // Counter wrap: one load edge, then 65530 retirements reach 0xFFFF, one more wraps
    applyStimulus(1'b1, 4'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    repeat (65530) tick();
    checkOutput("wrap_ffff", 32'(retired), 32'hFFFF);
    tick();
    checkOutput("wrap_zero", 32'(retired), 32'h0);

    // Reset asserted while a write to r4 is stalled in the stage
    applyStimulus(1'b1, 4'd4, 16'hCAFE, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("rst_pre_retired", 32'(retired), 32'h1);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    readAddr(4'd4, 4'd9);
    checkOutput("rst_pre_bypass", 32'(ra_data), 32'hCAFE);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_wb_valid", 32'(wb_valid), 32'h0);
    checkOutput("rst_async_wb_we", 32'(wb_we), 32'h0);
    checkOutput("rst_async_wb_rd", 32'(wb_rd), 32'h0);
    checkOutput("rst_async_wb_data", 32'(wb_data), 32'h0);
    checkOutput("rst_async_retired", 32'(retired), 32'h0);
    checkOutput("rst_async_ra_r4", 32'(ra_data), 32'h0);
    checkOutput("rst_async_rb_r9", 32'(rb_data), 32'h0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_after_r4", 32'(ra_data), 32'h0);
    checkOutput("rst_after_retired", 32'(retired), 32'h0);
    checkOutput("rst_after_wb_valid", 32'(wb_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_wb_stage
